// File: rtl/hazard_control_unit.sv
// Hazard controller for the 5-stage RV32I pipeline: stage enables, bubbles,
// flushes, PC redirect, plus stall and flush performance counters.
module hazard_control_unit #(
  parameter int LOAD_USE_STALLS = 1,
  parameter int REDIRECT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ifid_rs1,
  input  logic [4:0]  ifid_rs2,
  input  logic        ifid_rs1_used,
  input  logic        ifid_rs2_used,
  input  logic [4:0]  idex_rd,
  input  logic        idex_mem_read,
  input  logic        ex_mispredict,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        pc_redirect,
  output logic [1:0]  state_out,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  localparam logic [1:0] LU_RELOAD = 2'(LOAD_USE_STALLS - 1);
  localparam logic [1:0] RD_RELOAD = 2'(REDIRECT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] stall_count_q, flush_count_q;

  logic hz, mem_wait, flush_inc;
  logic pc_en_n, ifid_en_n, idex_en_n, exmem_en_n;
  logic ifid_flush_n, idex_flush_n, pc_redirect_n;

  assign hz = idex_mem_read && (idex_rd != 5'd0) &&
              ((ifid_rs1_used && (ifid_rs1 == idex_rd)) ||
               (ifid_rs2_used && (ifid_rs2 == idex_rd)));
  assign mem_wait = dmem_req && !dmem_ready;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    flush_inc     = 1'b0;
    pc_en_n       = 1'b1;
    ifid_en_n     = 1'b1;
    idex_en_n     = 1'b1;
    exmem_en_n    = 1'b1;
    ifid_flush_n  = 1'b0;
    idex_flush_n  = 1'b0;
    pc_redirect_n = 1'b0;

    if (state_q == MEM_WAIT) begin
      // Pending mispredict/HZ stay frozen in place and are seen in RUN next cycle.
      if (dmem_ready) begin
        state_d = RUN;
      end else begin
        pc_en_n    = 1'b0;
        ifid_en_n  = 1'b0;
        idex_en_n  = 1'b0;
        exmem_en_n = 1'b0;
      end
    end else if (mem_wait) begin
      pc_en_n    = 1'b0;
      ifid_en_n  = 1'b0;
      idex_en_n  = 1'b0;
      exmem_en_n = 1'b0;
      state_d    = MEM_WAIT;
      cnt_d      = 2'd0;
    end else if (ex_mispredict) begin
      pc_redirect_n = 1'b1;
      ifid_flush_n  = 1'b1;
      idex_flush_n  = 1'b1;
      flush_inc     = 1'b1;
      if (REDIRECT_CYCLES > 1) begin
        state_d = REDIRECT;
        cnt_d   = RD_RELOAD;
      end else begin
        state_d = RUN;
        cnt_d   = 2'd0;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (hz) begin
            pc_en_n      = 1'b0;
            ifid_en_n    = 1'b0;
            idex_flush_n = 1'b1;
            if (LOAD_USE_STALLS > 1) begin
              state_d = LU_STALL;
              cnt_d   = LU_RELOAD;
            end
          end
        end
        LU_STALL: begin
          pc_en_n      = 1'b0;
          ifid_en_n    = 1'b0;
          idex_flush_n = 1'b1;
          cnt_d        = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = RUN;
        end
        REDIRECT: begin
          ifid_flush_n = 1'b1;
          cnt_d        = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      cnt_q         <= 2'd0;
      stall_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pc_en_n)  stall_count_q <= stall_count_q + 32'd1;
      if (flush_inc) flush_count_q <= flush_count_q + 32'd1;
    end
  end

  // Reset holds the pipeline frozen and flushed regardless of the registered state.
  always_comb begin
    if (rst) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      pc_redirect = 1'b0;
      state_out   = RUN;
      stall_count = 32'd0;
      flush_count = 32'd0;
    end else begin
      pc_en       = pc_en_n;
      ifid_en     = ifid_en_n;
      idex_en     = idex_en_n;
      exmem_en    = exmem_en_n;
      ifid_flush  = ifid_flush_n;
      idex_flush  = idex_flush_n;
      pc_redirect = pc_redirect_n;
      state_out   = state_q;
      stall_count = stall_count_q;
      flush_count = flush_count_q;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with LOAD_USE_STALLS=2, REDIRECT_CYCLES=2.
module tb_hazard_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ifid_rs1, ifid_rs2, idex_rd;
  logic        ifid_rs1_used, ifid_rs2_used, idex_mem_read;
  logic        ex_mispredict, dmem_req, dmem_ready;
  logic        pc_en, ifid_en, idex_en, exmem_en;
  logic        ifid_flush, idex_flush, pc_redirect;
  logic [1:0]  state_out;
  logic [31:0] stall_count, flush_count;
  logic [6:0]  ctrl;

  int passed = 0;
  int total  = 0;

  // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, pc_redirect}
  localparam logic [6:0] C_DEF = 7'b1111_000;
  localparam logic [6:0] C_RST = 7'b0000_110;
  localparam logic [6:0] C_BUB = 7'b0011_010;
  localparam logic [6:0] C_MIS = 7'b1111_111;
  localparam logic [6:0] C_FRZ = 7'b0000_000;
  localparam logic [6:0] C_RDR = 7'b1111_100;

  hazard_control_unit #(.LOAD_USE_STALLS(2), .REDIRECT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_rs1_used(ifid_rs1_used), .ifid_rs2_used(ifid_rs2_used),
    .idex_rd(idex_rd), .idex_mem_read(idex_mem_read),
    .ex_mispredict(ex_mispredict), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .pc_redirect(pc_redirect),
    .state_out(state_out), .stall_count(stall_count), .flush_count(flush_count)
  );

  assign ctrl = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, pc_redirect};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag, input logic [6:0] c, input logic [1:0] st,
                           input logic [31:0] sc, input logic [31:0] fc);
    #1;
    chk({tag, "_ctrl"}, 32'(ctrl), 32'(c));
    chk({tag, "_state"}, 32'(state_out), 32'(st));
    chk({tag, "_stall"}, stall_count, sc);
    chk({tag, "_flush"}, flush_count, fc);
  endtask

  task automatic idle();
    ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; idex_rd = 5'd0;
    ifid_rs1_used = 1'b0; ifid_rs2_used = 1'b0; idex_mem_read = 1'b0;
    ex_mispredict = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic set_hz();
    idex_mem_read = 1'b1; idex_rd = 5'd5; ifid_rs2 = 5'd5; ifid_rs2_used = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    check_all("reset", C_RST, 2'd0, 0, 0);
    step();
    check_all("reset_held", C_RST, 2'd0, 0, 0);
    rst = 1'b0;
    check_all("post_reset", C_DEF, 2'd0, 0, 0);
    step();

    // Load-use with two bubbles
    set_hz();
    check_all("lu_c0", C_BUB, 2'd0, 0, 0);
    step();
    idle();
    check_all("lu_c1", C_BUB, 2'd1, 1, 0);
    step();
    check_all("lu_done", C_DEF, 2'd0, 2, 0);

    // No false hazards
    idex_mem_read = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs1_used = 1'b1;
    check_all("rd_zero", C_DEF, 2'd0, 2, 0);
    idex_rd = 5'd7; ifid_rs1 = 5'd7; ifid_rs1_used = 1'b0; ifid_rs2 = 5'd3; ifid_rs2_used = 1'b1;
    check_all("rs1_unused", C_DEF, 2'd0, 2, 0);
    step();
    idle();
    check_all("no_false", C_DEF, 2'd0, 2, 0);

    // Mispredict, two redirect cycles
    ex_mispredict = 1'b1;
    check_all("mis_c0", C_MIS, 2'd0, 2, 0);
    step();
    idle();
    check_all("mis_c1", C_RDR, 2'd3, 2, 1);
    step();
    check_all("mis_done", C_DEF, 2'd0, 2, 1);

    // Memory wait: three freeze cycles with a mispredict held behind it
    dmem_req = 1'b1; dmem_ready = 1'b0; ex_mispredict = 1'b1;
    check_all("mw_c0", C_FRZ, 2'd0, 2, 1);
    step();
    check_all("mw_c1", C_FRZ, 2'd2, 3, 1);
    step();
    check_all("mw_c2", C_FRZ, 2'd2, 4, 1);
    step();
    dmem_ready = 1'b1;
    check_all("mw_rel", C_DEF, 2'd2, 5, 1);
    step();
    dmem_req = 1'b0; dmem_ready = 1'b0;
    check_all("mw_mis", C_MIS, 2'd0, 5, 1);
    step();
    idle();
    check_all("mw_rdr", C_RDR, 2'd3, 5, 2);
    step();
    check_all("mw_done", C_DEF, 2'd0, 5, 2);

    // Mispredict outranks load-use
    set_hz();
    ex_mispredict = 1'b1;
    check_all("prio_c0", C_MIS, 2'd0, 5, 2);
    step();
    idle();
    check_all("prio_c1", C_RDR, 2'd3, 5, 3);
    step();
    check_all("prio_done", C_DEF, 2'd0, 5, 3);

    // Reset in the middle of a load-use stall
    set_hz();
    check_all("rlu_c0", C_BUB, 2'd0, 5, 3);
    step();
    idle();
    rst = 1'b1;
    check_all("rlu_rst", C_RST, 2'd0, 0, 0);
    step();
    check_all("rlu_held", C_RST, 2'd0, 0, 0);
    rst = 1'b0;
    check_all("rlu_release", C_DEF, 2'd0, 0, 0);
    step();
    check_all("rlu_idle", C_DEF, 2'd0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
